// File: rtl/muldiv_if.sv
// muldiv_if: start/operand/result bundle between the multicycle control
// datapath (master) and the iterative multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             MultCtrl;
  logic             DivCtrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             DivZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output MultCtrl, DivCtrl, a, b,
    input  busy, done, DivZero, hi, lo
  );

  modport slave (
    input  MultCtrl, DivCtrl, a, b,
    output busy, done, DivZero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply (radix-2 Booth) / divide (restoring)
// over WIDTH cycles, with a one-cycle done pulse and divide-by-zero flag.
// Optional feature macro: MULDIV_DIVZERO_TRAP_EN -- when defined, a divide
// by zero finishes immediately without writing hi/lo.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MULT    = 3'd1,
    ST_DIV     = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d, start_state_s;

  // Shared iteration storage: acc_hi is product-high (with a guard bit so a
  // most-negative multiplicand cannot overflow) or the partial remainder;
  // acc_lo is the multiplier or the dividend/quotient shift register.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, or |divisor|
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             q_m1_q, q_m1_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

  logic             start_mult_s, start_div_s, b_zero_s, last_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH:0]   booth_sum_s, booth_hi_s;
  logic [WIDTH-1:0] booth_lo_s;
  logic [WIDTH:0]   div_shift_s, div_rem_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_quo_s, quo_fix_s, rem_fix_s;

  // Decode start requests (multiply wins) and operand magnitudes.
  always_comb begin
    start_mult_s = bus.MultCtrl;
    start_div_s  = bus.DivCtrl & ~bus.MultCtrl;
    b_zero_s     = (bus.b == {WIDTH{1'b0}});
    abs_a_s      = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    abs_b_s      = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    last_s       = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State to enter when a start may be accepted (IDLE and DONE).
  always_comb begin
    if (start_mult_s) begin
      start_state_s = ST_MULT;
    end else if (start_div_s) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
      start_state_s = b_zero_s ? ST_DONE : ST_DIV;
`else
      start_state_s = ST_DIV;
`endif
    end else begin
      start_state_s = ST_IDLE;
    end
  end

  // One Booth step: add/subtract multiplicand, then arithmetic shift right.
  always_comb begin
    case ({acc_lo_q[0], q_m1_q})
      2'b01:   booth_sum_s = acc_hi_q + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum_s = acc_hi_q - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum_s = acc_hi_q;
    endcase
    booth_hi_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
    booth_lo_s = {booth_sum_s[0], acc_lo_q[WIDTH-1:1]};
  end

  // One restoring-divide step plus the final sign correction.
  always_comb begin
    div_shift_s = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
    div_rem_s   = div_ge_s ? (div_shift_s - {1'b0, mcand_q}) : div_shift_s;
    div_quo_s   = {acc_lo_q[WIDTH-2:0], div_ge_s};
    quo_fix_s   = qneg_q ? (-acc_lo_q) : acc_lo_q;
    rem_fix_s   = rneg_q ? (-acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = start_state_s;
      ST_MULT:    state_d = last_s ? ST_DONE : ST_MULT;
      ST_DIV:     state_d = last_s ? ST_DIV_FIX : ST_DIV;
      ST_DIV_FIX: state_d = ST_DONE;
      ST_DONE:    state_d = start_state_s;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    q_m1_d    = q_m1_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_mult_s) begin
          cnt_d    = {CNT_W{1'b0}};
          mcand_d  = bus.a;
          acc_hi_d = {(WIDTH+1){1'b0}};
          acc_lo_d = bus.b;
          q_m1_d   = 1'b0;
          qneg_d   = 1'b0;
          rneg_d   = 1'b0;
          divz_d   = 1'b0;
        end else if (start_div_s) begin
          cnt_d    = {CNT_W{1'b0}};
          mcand_d  = abs_b_s;
          acc_hi_d = {(WIDTH+1){1'b0}};
          acc_lo_d = abs_a_s;
          q_m1_d   = 1'b0;
          qneg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rneg_d   = bus.a[WIDTH-1];
          divz_d   = b_zero_s;
`ifdef MULDIV_DIVZERO_TRAP_EN
          done_d    = b_zero_s;
          divzero_d = b_zero_s;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MULT: begin
        acc_hi_d = booth_hi_s;
        acc_lo_d = booth_lo_s;
        q_m1_d   = acc_lo_q[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_s) begin
          hi_d   = booth_hi_s[WIDTH-1:0];
          lo_d   = booth_lo_s;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DIV: begin
        acc_hi_d = div_rem_s;
        acc_lo_d = div_quo_s;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      ST_DIV_FIX: begin
        hi_d      = rem_fix_s;
        lo_d      = quo_fix_s;
        done_d    = 1'b1;
        divzero_d = divz_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      acc_hi_q  <= {(WIDTH+1){1'b0}};
      acc_lo_q  <= {WIDTH{1'b0}};
      q_m1_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      q_m1_q    <= q_m1_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq at WIDTH=32.
module tb_muldiv_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference behaviour computed from signed arithmetic in 64 bits.
  function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (m) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 33;
    end else if (b == 32'h0) begin
      e.dz = 1'b1;
`ifdef MULDIV_DIVZERO_TRAP_EN
      e.hi = last_hi;
      e.lo = last_lo;
      e.lat = 1;
`else
      e.hi = a;
      e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.lat = 34;
`endif
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.lat = 34;
    end
    return e;
  endfunction

  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.MultCtrl = m;
    bus.DivCtrl  = d;
    bus.a        = a;
    bus.b        = b;
    sb_q.push_back(model(m, a, b));
  endtask

  task automatic clear_inputs();
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic wait_done(input int cyc0);
    int   cyc;
    logic busy_ok;
    exp_t e;
    cyc = cyc0;
    busy_ok = bus.busy;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      busy_ok = busy_ok & bus.busy;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("latency", 64'(cyc), 64'(e.lat));
      chk("hi", 64'(bus.hi), 64'(e.hi));
      chk("lo", 64'(bus.lo), 64'(e.lo));
      chk("divzero", 64'(bus.DivZero), 64'(e.dz));
      chk("busy_held", 64'(busy_ok), 64'd1);
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  task automatic idle_checks();
    @(posedge clk); #1;
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue(m, d, a, b);
    @(posedge clk); #1;
    clear_inputs();
    wait_done(1);
    idle_checks();
  endtask

  initial begin
    int dones;
    logic m;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_divzero", 64'(bus.DivZero), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;

    // Directed operations, including boundary operands.
    run_op(1'b1, 1'b0, 32'd7, -32'sd3);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b0, 1'b1, -32'sd7, 32'd2);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'd5, 32'd0);
    run_op(1'b0, 1'b1, -32'sd9, 32'd0);
    run_op(1'b1, 1'b1, 32'd6, -32'sd4);
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      m = 1'($urandom_range(0, 1));
      run_op(m, ~m, $urandom, (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom);
    end

    // Back-to-back: next start presented during the DONE cycle.
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd123, -32'sd45);
    @(posedge clk); #1;
    clear_inputs();
    wait_done(1);
    issue(1'b0, 1'b1, -32'sd1000, 32'd7);
    @(posedge clk); #1;
    clear_inputs();
    wait_done(1);
    idle_checks();

    // DivCtrl held while a multiply is busy must be ignored.
    @(negedge clk);
    issue(1'b1, 1'b0, -32'sd12345, 32'd678);
    @(posedge clk); #1;
    clear_inputs();
    bus.DivCtrl = 1'b1;
    bus.b = 32'h0;
    repeat (6) @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    wait_done(7);
    idle_checks();

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    bus.MultCtrl = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    @(posedge clk); #1;
    clear_inputs();
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_divzero", 64'(bus.DivZero), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    last_hi = 32'h0;
    last_lo = 32'h0;

    run_op(1'b0, 1'b1, 32'd100, -32'sd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised iterative signed multiply/divide unit for the multicycle datapath. It is started by the control unit's `MultCtrl`/`DivCtrl` pulses and runs a radix-2 Booth multiply or a restoring divide over `WIDTH` cycles. It returns HI/LO with a one-cycle `done` pulse and flags divide-by-zero, so the control FSM can wait for completion or raise an exception. It generalises the fixed 32-bit mult/div hooks to any even `WIDTH` and adds a busy/done handshake.

## Interface
- `WIDTH`, 32: operand width. Even, ≥4.
- `CNT_W`, `$clog2(WIDTH+1)`: iteration counter width.

Reset is synchronous, active-high; one clock.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous active-high reset
- `MultCtrl`  in  1  start signed multiply, sampled in IDLE
- `DivCtrl`  in  1  start signed divide, sampled in IDLE
- `a`  in  WIDTH  multiplicand / dividend (rs)
- `b`  in  WIDTH  multiplier / divisor (rt)
- `busy`  out  1  high from the cycle after start until `done`, inclusive
- `done`  out  1  one-cycle pulse; `hi`/`lo` valid and updated this cycle
- `DivZero`  out  1  one-cycle pulse with `done` when a divide had `b==0`
- `hi`  out  WIDTH  product upper half / remainder
- `lo`  out  WIDTH  product lower half / quotient

## Operation
- States: IDLE, MULT, DIV, DIV_FIX, DONE.
- Start handling in IDLE:
  - `MultCtrl` → MULT.
  - else `DivCtrl` → DIV.
  - Both high: multiply wins.
  - Operands are latched on the start edge; `a`/`b` are don't-care afterwards.
- MULT:
  - Booth radix-2 on a `2*WIDTH+1` accumulator: `{P_hi, P_lo=b, q-1=0}`.
  - Each cycle: add `a`, subtract `a`, or do nothing per `{P_lo[0], q-1}`, then arithmetic shift right 1.
  - `WIDTH` iterations, then DONE.
  - `{hi,lo}` = full signed `2*WIDTH` product.
- DIV:
  - Latch `|a|`, `|b|`, quotient sign `a[MSB]^b[MSB]`, remainder sign `a[MSB]`.
  - Restoring shift-subtract for `WIDTH` cycles.
  - DIV_FIX (1 cycle): negate the quotient/remainder as required, then DONE.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / −1: `lo` = most-negative (wraps), `hi` = 0, `DivZero` = 0.
- DONE (1 cycle):
  - Writes `hi`/`lo`; pulses `done`.
  - Returns to IDLE, or MULT/DIV directly if a start is present the same cycle.
- `MultCtrl`/`DivCtrl` are ignored while busy (MULT, DIV, DIV_FIX).
- `hi`/`lo` hold their last result between operations; they never show intermediate values.
- Reset, at any state including mid-operation:
  - Next state IDLE.
  - `busy`, `done`, `DivZero` = 0; `hi`, `lo` = 0.
  - Counter and accumulators cleared; the in-flight operation is discarded.

## Timing
- Start sampled on edge 0.
- Multiply: `done` high in cycle `WIDTH+1` (33 for `WIDTH=32`).
- Divide: `done` high in cycle `WIDTH+2` (34 for `WIDTH=32`).
- `busy` rises in cycle 1 and falls after the `done` cycle.
- Back-to-back: a start sampled in the DONE cycle begins the next op with no idle cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MULDIV_DIVZERO_TRAP_EN` defined:
  - Divide with `b==0` goes IDLE→DONE.
  - `done` and `DivZero` pulse in cycle 1.
  - `hi`/`lo` are NOT written (previous values held).
- `MULDIV_DIVZERO_TRAP_EN` undefined:
  - Divide by zero runs the full `WIDTH+2` cycles; `DivZero` still pulses with `done`.
  - Result: `lo` = all-ones if `a≥0`, else 1; `hi` = `a`.

## Test plan
- `WIDTH=32`, multiply `a=7`, `b=-3` → `done` at cycle 33; `hi=FFFFFFFF`, `lo=FFFFFFEB`; `busy` high cycles 1–33.
- Multiply `a=b=80000000` → `hi=40000000`, `lo=00000000`.
- Divide `a=-7`, `b=2` → `done` at cycle 34; `lo=FFFFFFFD`, `hi=FFFFFFFF`, `DivZero=0`.
- Divide `a=80000000`, `b=FFFFFFFF` → `lo=80000000`, `hi=0`.
- Divide `a=5`, `b=0`:
  - With macro: `done` and `DivZero` at cycle 1; `hi`/`lo` unchanged.
  - Without macro: `done` and `DivZero` at cycle 34; `lo=FFFFFFFF`, `hi=5`.
- Start multiply, assert `reset` at cycle 10, then `DivCtrl` is ignored while busy:
  - Next cycle: `busy=0`, `hi=lo=0`, no `done` pulse.
  - Separately, `MultCtrl` and `DivCtrl` asserted together → multiply result only.
